// File: rtl/pezaris_seq_mult_ctrl.sv
// Iterative signed multiplier: one Pezaris carry-save row reused WIDTH times, then a resolve add.
// Optional performance counters are enabled with `define PEZARIS_PERF_EN.
module pezaris_seq_mult_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
`ifdef PEZARIS_PERF_EN
  output logic [31:0]          op_count,
  output logic [31:0]          busy_cycles,
`endif
  output logic                 busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROW     = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state, next_state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   sum_q, carry_q;
  logic [PW-1:0]   term, row_x, sum_n, carry_n;
  logic            row_cin;
  logic            accept, last_row, release_out;

  assign accept      = (state == IDLE) && in_valid && in_ready;
  assign last_row    = (cnt == CW'(WIDTH - 1));
  assign release_out = (state == DONE) && out_ready;

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ROW;
      ROW:     if (last_row) next_state = RESOLVE;
      RESOLVE: next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Carry-save row: the sign row adds ~(term<<i) and injects the +1 at carry bit 0.
  always_comb begin
    term    = {{WIDTH{a_q[WIDTH-1]}}, a_q} & {PW{b_q[cnt]}};
    row_x   = term << cnt;
    row_cin = 1'b0;
    if (last_row) begin
      row_x   = ~row_x;
      row_cin = 1'b1;
    end
    sum_n   = sum_q ^ carry_q ^ row_x;
    carry_n = {((sum_q & carry_q) | (sum_q & row_x) | (carry_q & row_x)), row_cin} >> 0 == '0
              ? '0 : PW'({((sum_q & carry_q) | (sum_q & row_x) | (carry_q & row_x)), row_cin});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == DONE);
      busy      <= (next_state != IDLE);
    end
  end

  // Operand capture, row sequencing and the final resolve add.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      cnt     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      p       <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q     <= a;
          b_q     <= b;
          cnt     <= '0;
          sum_q   <= '0;
          carry_q <= '0;
        end
        ROW: begin
          sum_q   <= sum_n;
          carry_q <= carry_n;
          if (!last_row) cnt <= cnt + CW'(1);
        end
        RESOLVE: p <= sum_q + carry_q;
        default: ;
      endcase
    end
  end

`ifdef PEZARIS_PERF_EN
  // Completed-product and busy-cycle counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count    <= '0;
      busy_cycles <= '0;
    end else begin
      if (release_out) op_count <= op_count + 32'd1;
      if (busy)        busy_cycles <= busy_cycles + 32'd1;
    end
  end
`else
  logic unused_release;
  assign unused_release = release_out;
`endif

endmodule

// File: tb/tb_pezaris_seq_mult_ctrl.sv
// Scoreboard bench for pezaris_seq_mult_ctrl (WIDTH=8); checks products, latency, spacing and reset abort.
module tb_pezaris_seq_mult_ctrl;

  localparam int unsigned W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [W-1:0]    a, b;
  logic            out_valid, out_ready;
  logic [2*W-1:0]  p;
  logic            busy;
`ifdef PEZARIS_PERF_EN
  logic [31:0]     op_count, busy_cycles;
`endif

  int total = 0;
  int bad   = 0;

  logic [2*W-1:0] exp_q[$];
  int  cyc = 0;
  int  acc_cyc = 0;
  int  prev_acc = -1;
  bit  chk_space = 1'b0;
  logic prev_ov = 1'b0;

  pezaris_seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .p(p),
`ifdef PEZARIS_PERF_EN
    .op_count(op_count), .busy_cycles(busy_cycles),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy, r;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    r  = sx * sy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Accept tracking, latency/spacing checks and product monitor share one edge process.
  always @(posedge clk) begin
    int n;
    n = cyc + 1;
    cyc <= n;
    if (rst) begin
      exp_q.delete();
      prev_acc <= -1;
      prev_ov  <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mul(a, b));
        acc_cyc <= n;
        if (chk_space && prev_acc >= 0) chk("accept_spacing", 64'(n - prev_acc), 64'(W + 3));
        prev_acc <= chk_space ? n : -1;
      end
      if (out_valid && !prev_ov) chk("latency", 64'(n - acc_cyc), 64'(W + 2));
      prev_ov <= out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_product: got %0h want none", p);
        end else begin
          chk("product", 64'(p), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    int k;
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin total++; bad++; $display("FAIL accept_timeout: got in_ready=0 want 1"); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) begin total++; bad++; $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size()); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [2*W-1:0] held;
    int k;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_p", 64'(p), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    // Directed products.
    issue(8'd5, 8'hFD);  drain(); chk("p_5x-3", 64'(p), 64'hFFF1);
    issue(8'h80, 8'h80); drain(); chk("p_min_x_min", 64'(p), 64'h4000);
    issue(8'd127, 8'h80); drain(); chk("p_127x-128", 64'(p), 64'hC080);
    issue(8'hFF, 8'hFF); drain(); chk("p_-1x-1", 64'(p), 64'h0001);
    issue(8'd0, 8'd0);   drain(); chk("p_zero", 64'(p), 64'h0000);

    // Backpressure in DONE.
    out_ready = 1'b0;
    issue(8'hF9, 8'd9);
    k = 0;
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    held = p;
    chk("hold_p_value", 64'(held), 64'hFFC1);
    a = 8'd1; b = 8'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_p", 64'(p), 64'(held));
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    issue(8'd3, 8'd4); drain(); chk("p_3x4", 64'(p), 64'd12);

    // Reset during ROW cycle 4 aborts the operation.
    issue(8'd7, 8'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_p", 64'(p), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    repeat (15) @(negedge clk);
    chk("abort_no_pending", 64'(exp_q.size()), 64'd0);

`ifdef PEZARIS_PERF_EN
    begin
      logic [31:0] oc0, bc0;
      oc0 = op_count; bc0 = busy_cycles;
      issue(8'd2, 8'd3); drain();
      issue(8'hFE, 8'd3); drain();
      issue(8'd9, 8'hF0); drain();
      chk("perf_op_count", 64'(op_count - oc0), 64'd3);
      chk("perf_busy_cycles", 64'(busy_cycles - bc0), 64'(3 * (W + 2)));
    end
`endif

    // Back-to-back accepts with in_valid held high.
    chk_space = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      k = 0;
      while (!in_ready && k < 50) begin @(negedge clk); k++; end
      if (k >= 50) begin total++; bad++; $display("FAIL b2b_timeout: got in_ready=0 want 1"); end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk_space = 1'b0;
    drain();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
